// File: rtl/serial_pkg.sv
// Shared definitions for the measurement serial transmitter: outer FSM state
// codes, ASCII constants and the BCD digit to ASCII mapping.
package serial_pkg;

  typedef enum logic [3:0] {
    REPOUSO   = 4'h0,
    CARREGA   = 4'h1,
    TRANSMITE = 4'h2,
    FIM       = 4'hF
  } estado_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_ERR  = 8'h3F;

  localparam int DIVISOR_115200 = 434;

  // Digits above 9 are not valid BCD and are shown as '?'.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
    if (d <= 4'd9) return ASCII_ZERO + {4'h0, d};
    return ASCII_ERR;
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 character transmitter: start bit, 8 data bits LSB first, stop bit,
// each held DIVISOR clock cycles; pronto pulses the cycle after the stop bit.
module uart_tx_8n1
  import serial_pkg::*;
#(
  parameter int DIVISOR = DIVISOR_115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dados,
  output logic       saida_serial,
  output logic       pronto
);

  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    shift;
  logic          ativo;

  // The line is bit 0 of the frame register, so it idles at mark via the
  // all-ones reset value and the stop bit left in place after the last shift.
  assign saida_serial = shift[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '1;
      ativo   <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      pronto <= 1'b0;
      if (!ativo) begin
        if (partida) begin
          shift   <= {1'b1, dados, 1'b0};
          cnt     <= '0;
          bit_idx <= '0;
          ativo   <= 1'b1;
        end
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (bit_idx == 4'd9) begin
          ativo  <= 1'b0;
          pronto <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          shift   <= {1'b1, shift[9:1]};
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_medida_serial.sv
// Sends a latched 3-digit BCD distance as four ASCII characters
// (hundreds, tens, units, '#') over an 8N1 serial line.
module tx_medida_serial
  import serial_pkg::*;
#(
  parameter int DIVISOR = DIVISOR_115200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [11:0] medida,
  output logic        saida_serial,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  // Handshake: partida is a request accepted only in REPOUSO (dropped, not
  // queued, while ocupado=1); pronto is a one-cycle completion pulse with no
  // backpressure, and ocupado falls on the edge after it.
  estado_t     estado;
  logic [1:0]  indice;
  logic [11:0] medida_q;
  logic [7:0]  caractere;
  logic        tx_partida;
  logic        tx_pronto;

  always_comb begin
    caractere = ASCII_HASH;
    case (indice)
      2'd0:    caractere = bcd_to_ascii(medida_q[11:8]);
      2'd1:    caractere = bcd_to_ascii(medida_q[7:4]);
      2'd2:    caractere = bcd_to_ascii(medida_q[3:0]);
      default: caractere = ASCII_HASH;
    endcase
  end

  assign tx_partida = (estado == CARREGA);
  assign db_estado  = estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= REPOUSO;
      indice   <= '0;
      medida_q <= '0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
    end else begin
      case (estado)
        REPOUSO: begin
          if (partida) begin
            medida_q <= medida;
            indice   <= '0;
            ocupado  <= 1'b1;
            estado   <= CARREGA;
          end
        end
        CARREGA: estado <= TRANSMITE;
        TRANSMITE: begin
          if (tx_pronto) begin
            if (indice == 2'd3) begin
              pronto <= 1'b1;
              estado <= FIM;
            end else begin
              indice <= indice + 2'd1;
              estado <= CARREGA;
            end
          end
        end
        FIM: begin
          pronto  <= 1'b0;
          ocupado <= 1'b0;
          estado  <= REPOUSO;
        end
        default: begin
          pronto  <= 1'b0;
          ocupado <= 1'b0;
          estado  <= REPOUSO;
        end
      endcase
    end
  end

  uart_tx_8n1 #(.DIVISOR(DIVISOR)) u_uart (
    .clock        (clock),
    .reset        (reset),
    .partida      (tx_partida),
    .dados        (caractere),
    .saida_serial (saida_serial),
    .pronto       (tx_pronto)
  );

endmodule

// File: tb/tb_tx_medida_serial.sv
// Directed bench for tx_medida_serial with DIVISOR=4: checks line waveform,
// decoded bytes, state codes and pronto/ocupado timing per frame.
module tb_tx_medida_serial;

  localparam int DIV  = 4;
  localparam int CH   = 10 * DIV + 2;      // character plus 2 mark cycles
  localparam int LAST = 2 + 40 * DIV + 6;  // pronto cycle after the partida edge

  logic        clock;
  logic        reset;
  logic        partida;
  logic [11:0] medida;
  logic        saida_serial;
  logic        ocupado;
  logic        pronto;
  logic [3:0]  db_estado;

  int total;
  int bad;

  tx_medida_serial #(.DIVISOR(DIV)) dut (
    .clock        (clock),
    .reset        (reset),
    .partida      (partida),
    .medida       (medida),
    .saida_serial (saida_serial),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle c counts from the cycle that begins at the edge sampling partida.
  function automatic logic exp_line(input int c, input logic [31:0] e);
    int rel, ch, off, b;
    logic [7:0] byt;
    if (c < 1) return 1'b1;
    rel = c - 1;
    ch  = rel / CH;
    off = rel % CH;
    if (ch > 3 || off >= 10 * DIV) return 1'b1;
    b = off / DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    byt = e[ch*8 +: 8];
    return byt[b-1];
  endfunction

  function automatic logic [3:0] exp_state(input int c);
    if (c == 0) return 4'h1;
    if (c == LAST) return 4'hF;
    if (c > LAST) return 4'h0;
    if (((c - 1) % CH) == CH - 1) return 4'h1;
    return 4'h2;
  endfunction

  // mode 0 plain, 1 busy re-trigger, 2 partida in FIM, 3 chain (returns in
  // the first cycle after pronto without advancing the clock)
  task automatic run_frame(input string name, input logic [11:0] m,
                           input logic [31:0] e, input int mode, input bit skip_start);
    int last, line_bad, st_bad, oc_bad, pr_cnt, pr_at, rel, ch, off, b;
    logic [31:0] rx;
    if (!skip_start) begin
      medida  = m;
      partida = 1'b1;
    end
    @(posedge clock); #1;
    partida  = 1'b0;
    last     = (mode == 3) ? LAST + 1 : LAST + 7;
    line_bad = -1;
    st_bad   = -1;
    oc_bad   = -1;
    pr_cnt   = 0;
    pr_at    = -1;
    rx       = 'x;
    for (int c = 0; c <= last; c++) begin
      if (saida_serial !== exp_line(c, e) && line_bad < 0) line_bad = c;
      if (db_estado !== exp_state(c) && st_bad < 0) st_bad = c;
      if (ocupado !== (c <= LAST) && oc_bad < 0) oc_bad = c;
      if (pronto === 1'b1) begin
        pr_cnt++;
        pr_at = c;
      end
      if (c >= 1) begin
        rel = c - 1;
        ch  = rel / CH;
        off = rel % CH;
        b   = off / DIV;
        if (ch < 4 && off < 10 * DIV && (off % DIV) == DIV / 2 && b >= 1 && b <= 8)
          rx[ch*8 + b - 1] = saida_serial;
      end
      if (mode == 1 && c == 50) begin
        medida  = 12'h999;
        partida = 1'b1;
      end else if (mode == 1 && c == 51) begin
        partida = 1'b0;
      end
      if (mode == 2 && c == LAST) partida = 1'b1;
      else if (mode == 2 && c == LAST + 1) partida = 1'b0;
      if (!(mode == 3 && c == last)) begin
        @(posedge clock); #1;
      end
    end
    total++;
    if (line_bad !== -1) begin
      bad++;
      $display("FAIL %s line: first wrong cycle=%0d required=-1", name, line_bad);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx[i*8 +: 8] !== e[i*8 +: 8]) begin
        bad++;
        $display("FAIL %s byte%0d: got=%h required=%h", name, i, rx[i*8 +: 8], e[i*8 +: 8]);
      end
    end
    total++;
    if (st_bad !== -1) begin
      bad++;
      $display("FAIL %s db_estado: first wrong cycle=%0d required=-1", name, st_bad);
    end
    total++;
    if (oc_bad !== -1) begin
      bad++;
      $display("FAIL %s ocupado: first wrong cycle=%0d required=-1", name, oc_bad);
    end
    total++;
    if (pr_cnt !== 1) begin
      bad++;
      $display("FAIL %s pronto_count: got=%0d required=1", name, pr_cnt);
    end
    total++;
    if (pr_at !== LAST) begin
      bad++;
      $display("FAIL %s pronto_cycle: got=%0d required=%0d", name, pr_at, LAST);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      partida = 1'($urandom_range(0, 1));
      medida  = 12'($urandom_range(0, 4095));
      @(posedge clock); #1;
    end
    total++;
    if (saida_serial !== 1'b1) begin bad++; $display("FAIL reset saida: got=%b required=1", saida_serial); end
    total++;
    if (ocupado !== 1'b0) begin bad++; $display("FAIL reset ocupado: got=%b required=0", ocupado); end
    total++;
    if (pronto !== 1'b0) begin bad++; $display("FAIL reset pronto: got=%b required=0", pronto); end
    total++;
    if (db_estado !== 4'h0) begin bad++; $display("FAIL reset db_estado: got=%h required=0", db_estado); end
    partida = 1'b0;
    reset   = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_normal();
    run_frame("normal", 12'h123, {8'h23, 8'h33, 8'h32, 8'h31}, 0, 1'b0);
  endtask

  task automatic test_invalid_digit();
    run_frame("invalid", 12'h0A7, {8'h23, 8'h37, 8'h3F, 8'h30}, 0, 1'b0);
  endtask

  task automatic test_busy();
    run_frame("busy", 12'h045, {8'h23, 8'h35, 8'h34, 8'h30}, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int pr_seen;
    medida  = 12'h123;
    partida = 1'b1;
    @(posedge clock); #1;
    partida = 1'b0;
    // cycle 48 lies in data bit 0 of the second character ('2', bit 0 = 0)
    repeat (48) begin @(posedge clock); #1; end
    total++;
    if (saida_serial !== 1'b0) begin bad++; $display("FAIL rst_mid pre_line: got=%b required=0", saida_serial); end
    reset = 1'b0;
    #1;
    total++;
    if (saida_serial !== 1'b1) begin bad++; $display("FAIL rst_mid saida: got=%b required=1", saida_serial); end
    total++;
    if (ocupado !== 1'b0) begin bad++; $display("FAIL rst_mid ocupado: got=%b required=0", ocupado); end
    total++;
    if (db_estado !== 4'h0) begin bad++; $display("FAIL rst_mid db_estado: got=%h required=0", db_estado); end
    pr_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (pronto !== 1'b0) pr_seen++;
      @(posedge clock); #1;
    end
    total++;
    if (pr_seen !== 0) begin bad++; $display("FAIL rst_mid pronto: got=%0d required=0", pr_seen); end
    reset = 1'b1;
    @(posedge clock); #1;
    run_frame("after_rst", 12'h999, {8'h23, 8'h39, 8'h39, 8'h39}, 0, 1'b0);
  endtask

  task automatic test_fim_partida();
    run_frame("fim_partida", 12'h680, {8'h23, 8'h30, 8'h38, 8'h36}, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_first", 12'h321, {8'h23, 8'h31, 8'h32, 8'h33}, 3, 1'b0);
    medida  = 12'h0F9;
    partida = 1'b1;
    run_frame("b2b_second", 12'h0F9, {8'h23, 8'h39, 8'h3F, 8'h30}, 0, 1'b1);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    partida = 1'b0;
    medida  = '0;
    test_reset();
    test_normal();
    test_invalid_digit();
    test_busy();
    test_reset_mid();
    test_fim_partida();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
